// File: rtl/mpu_motion_detector.sv
// mpu_motion_detector
//   Assembles accelerometer bytes streamed by the MPU6050 register sequencer
//   into signed 16-bit X/Y/Z samples. At every completed frame it runs
//   debounced, hysteretic tilt detection on X (and optional shake detection).
//   It then raises RESCAN to request the next frame.
//
// Optional feature macro: SHAKE_DETECT_EN
//   defined   -> shake detection (Xprev, hit and window counters) is built
//   undefined -> o_shake is tied low; tilt behaviour and timing are unchanged
//
// Ports
//   i_mclk       system clock (only clock)
//   i_nrst       asynchronous active-low reset
//   i_tic        clock-enable strobe shared with sequencer / I2C master
//   i_load       byte valid from sequencer (qualified by i_tic)
//   i_adr[3:0]   register index of i_data (0..5 = XH,XL,YH,YL,ZH,ZL)
//   i_data[7:0]  register byte
//   i_completed  frame-done level from sequencer (qualified by i_tic)
//   o_rescan     request for the next frame
//   o_xout/o_yout/o_zout  last evaluated sample (signed)
//   o_tilt[1:0]  00 level, 01 right, 10 left
//   o_tilt_evt   one-cycle pulse when o_tilt changes
//   o_shake      one-cycle pulse on shake detection
module mpu_motion_detector #(
  parameter logic signed [15:0] THRESH       = 16'sd4000,
  parameter logic signed [15:0] HYST         = 16'sd1000,
  parameter int unsigned        DEBOUNCE     = 3,
  parameter logic        [16:0] SHAKE_DELTA  = 17'd12000,
  parameter int unsigned        SHAKE_COUNT  = 4,
  parameter int unsigned        SHAKE_WINDOW = 32
) (
  input  logic        i_mclk,
  input  logic        i_nrst,
  input  logic        i_tic,
  input  logic        i_load,
  input  logic [3:0]  i_adr,
  input  logic [7:0]  i_data,
  input  logic        i_completed,
  output logic        o_rescan,
  output logic [15:0] o_xout,
  output logic [15:0] o_yout,
  output logic [15:0] o_zout,
  output logic [1:0]  o_tilt,
  output logic        o_tilt_evt,
  output logic        o_shake
);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_REQ} state_t;

  localparam logic [1:0] TILT_LEVEL = 2'b00;
  localparam logic [1:0] TILT_RIGHT = 2'b01;
  localparam logic [1:0] TILT_LEFT  = 2'b10;

  localparam logic signed [15:0] L_THR_N  = -THRESH;
  localparam logic signed [15:0] L_EXIT   = THRESH - HYST;
  localparam logic signed [15:0] L_EXIT_N = -L_EXIT;
  localparam logic [3:0]         L_DEB    = 4'(DEBOUNCE);

  state_t             r_state;
  logic [7:0]         r_xh, r_xl, r_yh, r_yl, r_zh, r_zl;
  logic signed [15:0] r_x, r_y, r_z;
  logic [1:0]         r_tilt;
  logic [1:0]         r_last_cand;
  logic [3:0]         r_deb_cnt;
  logic               r_tilt_evt;
  logic               r_rescan;

  logic               w_wr;
  logic [7:0]         w_xh, w_xl, w_yh, w_yl, w_zh, w_zl;
  logic [1:0]         w_cand;
  logic [3:0]         w_cnt_inc;

  // Staging capture; runs regardless of FSM state
  assign w_wr = i_tic & i_load;

  always_ff @(posedge i_mclk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_xh <= '0; r_xl <= '0;
      r_yh <= '0; r_yl <= '0;
      r_zh <= '0; r_zl <= '0;
    end else if (w_wr) begin
      case (i_adr)
        4'd0:    r_xh <= i_data;
        4'd1:    r_xl <= i_data;
        4'd2:    r_yh <= i_data;
        4'd3:    r_yl <= i_data;
        4'd4:    r_zh <= i_data;
        4'd5:    r_zl <= i_data;
        default: ;
      endcase
    end
  end

  // Bypass so a byte landing on the COMPLETED edge is part of the sample
  assign w_xh = (w_wr && i_adr == 4'd0) ? i_data : r_xh;
  assign w_xl = (w_wr && i_adr == 4'd1) ? i_data : r_xl;
  assign w_yh = (w_wr && i_adr == 4'd2) ? i_data : r_yh;
  assign w_yl = (w_wr && i_adr == 4'd3) ? i_data : r_yl;
  assign w_zh = (w_wr && i_adr == 4'd4) ? i_data : r_zh;
  assign w_zl = (w_wr && i_adr == 4'd5) ? i_data : r_zl;

  // Tilt candidate: entry at THRESH, exit at THRESH-HYST, direct swap allowed
  always_comb begin
    w_cand = TILT_LEVEL;
    case (r_tilt)
      TILT_RIGHT: begin
        if (r_x < L_THR_N)     w_cand = TILT_LEFT;
        else if (r_x > L_EXIT) w_cand = TILT_RIGHT;
        else                   w_cand = TILT_LEVEL;
      end
      TILT_LEFT: begin
        if (r_x > THRESH)        w_cand = TILT_RIGHT;
        else if (r_x < L_EXIT_N) w_cand = TILT_LEFT;
        else                     w_cand = TILT_LEVEL;
      end
      default: begin
        if (r_x > THRESH)       w_cand = TILT_RIGHT;
        else if (r_x < L_THR_N) w_cand = TILT_LEFT;
        else                    w_cand = TILT_LEVEL;
      end
    endcase
  end

  // A candidate differing from last frame's candidate restarts the count
  assign w_cnt_inc = (w_cand != r_last_cand) ? 4'd1 : r_deb_cnt + 4'd1;

  always_ff @(posedge i_mclk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_tilt      <= TILT_LEVEL;
      r_last_cand <= TILT_LEVEL;
      r_deb_cnt   <= '0;
      r_tilt_evt  <= 1'b0;
      r_rescan    <= 1'b0;
    end else begin
      r_tilt_evt <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_tic && i_completed) begin
            r_x     <= {w_xh, w_xl};
            r_y     <= {w_yh, w_yl};
            r_z     <= {w_zh, w_zl};
            r_state <= S_EVAL;
          end
        end
        S_EVAL: begin
          r_last_cand <= w_cand;
          if (w_cand == r_tilt) begin
            r_deb_cnt <= '0;
          end else if (w_cnt_inc == L_DEB) begin
            r_tilt     <= w_cand;
            r_deb_cnt  <= '0;
            r_tilt_evt <= 1'b1;
          end else begin
            r_deb_cnt <= w_cnt_inc;
          end
          r_state <= S_REQ;
        end
        S_REQ: begin
          // First REQ cycle raises RESCAN; it then holds until a TIC cycle ends
          if (!r_rescan) begin
            r_rescan <= 1'b1;
          end else if (i_tic) begin
            r_rescan <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SHAKE_DETECT_EN
  localparam logic [3:0] L_SCNT = 4'(SHAKE_COUNT);
  localparam logic [7:0] L_SWIN = 8'(SHAKE_WINDOW);

  logic signed [15:0] r_xprev;
  logic               r_xprev_vld;
  logic [3:0]         r_hits;
  logic [7:0]         r_win;
  logic               r_shake;

  logic signed [16:0] w_diff;
  logic [16:0]        w_mag;
  logic               w_hit;
  logic [3:0]         w_hits_nxt;
  logic [7:0]         w_win_nxt;

  // 17-bit difference cannot overflow; magnitude of -65535 still fits
  assign w_diff     = {r_x[15], r_x} - {r_xprev[15], r_xprev};
  assign w_mag      = w_diff[16] ? (17'd0 - w_diff) : w_diff;
  assign w_hit      = (w_mag > SHAKE_DELTA);
  assign w_hits_nxt = (w_hit && r_hits != 4'd15) ? r_hits + 4'd1 : r_hits;
  assign w_win_nxt  = r_win + 8'd1;

  always_ff @(posedge i_mclk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_xprev     <= '0;
      r_xprev_vld <= 1'b0;
      r_hits      <= '0;
      r_win       <= '0;
      r_shake     <= 1'b0;
    end else begin
      r_shake <= 1'b0;
      if (r_state == S_EVAL) begin
        r_xprev     <= r_x;
        r_xprev_vld <= 1'b1;
        // First frame after reset only primes Xprev
        if (r_xprev_vld) begin
          if (w_hits_nxt >= L_SCNT) begin
            r_shake <= 1'b1;
            r_hits  <= '0;
            r_win   <= '0;
          end else if (w_win_nxt >= L_SWIN) begin
            r_hits <= '0;
            r_win  <= '0;
          end else begin
            r_hits <= w_hits_nxt;
            r_win  <= w_win_nxt;
          end
        end
      end
    end
  end

  assign o_shake = r_shake;
`else
  logic w_unused_shake_cfg;
  assign w_unused_shake_cfg = ^{SHAKE_DELTA, 4'(SHAKE_COUNT), 8'(SHAKE_WINDOW)};
  assign o_shake = 1'b0;
`endif

  assign o_rescan   = r_rescan;
  assign o_xout     = r_x;
  assign o_yout     = r_y;
  assign o_zout     = r_z;
  assign o_tilt     = r_tilt;
  assign o_tilt_evt = r_tilt_evt;

endmodule

// File: tb/tb_mpu_motion_detector.sv
module tb_mpu_motion_detector;

  logic        clk = 1'b0;
  logic        nrst;
  logic        tic;
  logic        load;
  logic [3:0]  adr;
  logic [7:0]  data;
  logic        comp;
  logic        o_rescan;
  logic [15:0] o_xout, o_yout, o_zout;
  logic [1:0]  o_tilt;
  logic        o_tilt_evt;
  logic        o_shake;

`ifdef SHAKE_DETECT_EN
  localparam bit SHK = 1'b1;
`else
  localparam bit SHK = 1'b0;
`endif

  mpu_motion_detector dut (
    .i_mclk      (clk),
    .i_nrst      (nrst),
    .i_tic       (tic),
    .i_load      (load),
    .i_adr       (adr),
    .i_data      (data),
    .i_completed (comp),
    .o_rescan    (o_rescan),
    .o_xout      (o_xout),
    .o_yout      (o_yout),
    .o_zout      (o_zout),
    .o_tilt      (o_tilt),
    .o_tilt_evt  (o_tilt_evt),
    .o_shake     (o_shake)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [15:0] x, y, z;
    logic [1:0]  tilt;
    int          evt;
    int          shk;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   frames_done = 0;

  task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s [frame %0d]: got 0x%0h, required 0x%0h", nm, id, act, req);
    end
  endtask

  // Monitor: pulses are counted per frame; the frame is scored when RESCAN rises
  logic prev_rsc = 1'b0;
  int   evt_cnt = 0;
  int   sh_cnt = 0;
  int   tic_hi = 0;
  int   cur_id = 0;
  exp_t e_mon;

  always @(negedge clk) begin
    if (o_tilt_evt === 1'b1) evt_cnt++;
    if (o_shake === 1'b1) sh_cnt++;
    if (o_rescan === 1'b1 && tic === 1'b1) tic_hi++;
    if (o_rescan === 1'b1 && !prev_rsc) begin
      if (q.size() == 0) begin
        check("unexpected_rescan", cur_id, 32'd1, 32'd0);
      end else begin
        e_mon  = q.pop_front();
        cur_id = e_mon.id;
        check("xout",      e_mon.id, {16'd0, o_xout}, {16'd0, e_mon.x});
        check("yout",      e_mon.id, {16'd0, o_yout}, {16'd0, e_mon.y});
        check("zout",      e_mon.id, {16'd0, o_zout}, {16'd0, e_mon.z});
        check("tilt",      e_mon.id, {30'd0, o_tilt}, {30'd0, e_mon.tilt});
        check("tilt_evt",  e_mon.id, evt_cnt, e_mon.evt);
        check("shake",     e_mon.id, sh_cnt, e_mon.shk);
      end
      evt_cnt = 0;
      sh_cnt  = 0;
    end
    if (o_rescan !== 1'b1 && prev_rsc) begin
      check("rescan_tic_cycles", cur_id, tic_hi, 1);
      tic_hi = 0;
      frames_done++;
    end
    prev_rsc = (o_rescan === 1'b1);
  end

  // One TIC period: three idle cycles then one TIC-high cycle carrying the inputs
  task automatic tick(input logic ld, input logic [3:0] a, input logic [7:0] d, input logic cp);
    repeat (3) begin
      @(posedge clk); #1;
      tic = 1'b0; load = 1'b0; comp = 1'b0;
    end
    @(posedge clk); #1;
    tic = 1'b1; load = ld; adr = a; data = d; comp = cp;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    tic = 1'b0; load = 1'b0; comp = 1'b0; adr = '0; data = '0;
    #2 nrst = 1'b0;
    #1;
    check("rst_xout",     0, {16'd0, o_xout}, 32'd0);
    check("rst_yout",     0, {16'd0, o_yout}, 32'd0);
    check("rst_zout",     0, {16'd0, o_zout}, 32'd0);
    check("rst_tilt",     0, {30'd0, o_tilt}, 32'd0);
    check("rst_tilt_evt", 0, {31'd0, o_tilt_evt}, 32'd0);
    check("rst_shake",    0, {31'd0, o_shake}, 32'd0);
    check("rst_rescan",   0, {31'd0, o_rescan}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3 nrst = 1'b1;
  endtask

  // Streams one frame; XL arrives on the COMPLETED tick to exercise the bypass.
  // full=0 sends only the low bytes so high bytes come from (cleared) staging.
  task automatic frame(input int id, input logic signed [15:0] x, input logic [1:0] tl,
                       input int ev, input int sh, input bit full);
    logic [15:0] y;
    logic [15:0] z;
    exp_t        e;
    int          target;
    y = ~x;
    z = x ^ 16'h5A5A;
    e.id   = id;
    e.x    = full ? x : {8'h00, x[7:0]};
    e.y    = full ? y : {8'h00, y[7:0]};
    e.z    = full ? z : {8'h00, z[7:0]};
    e.tilt = tl;
    e.evt  = ev;
    e.shk  = SHK ? sh : 0;
    q.push_back(e);
    target = frames_done + 1;
    if (full) tick(1'b1, 4'd0, x[15:8], 1'b0);
    if (full) tick(1'b1, 4'd2, y[15:8], 1'b0);
    tick(1'b1, 4'd3, y[7:0], 1'b0);
    if (full) tick(1'b1, 4'd4, z[15:8], 1'b0);
    tick(1'b1, 4'd5, z[7:0], 1'b0);
    tick(1'b1, 4'd7, 8'hFF, 1'b0);
    tick(1'b1, 4'd1, x[7:0], 1'b1);
    // First wait tick re-asserts COMPLETED while in REQ; it must be ignored
    for (int k = 0; k < 12 && frames_done < target; k++) tick(1'b0, 4'd0, 8'd0, k == 0);
    if (frames_done < target) check("frame_timeout", id, frames_done, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b1; tic = 1'b0; load = 1'b0; comp = 1'b0; adr = '0; data = '0;
    do_reset();
    repeat (3) tick(1'b0, 4'd0, 8'd0, 1'b0);
    check("idle_no_rescan", 0, {31'd0, o_rescan}, 32'd0);

    // Tilt entry with debounce, hysteresis hold, and return to level
    frame( 1,  16'sd4096, 2'b00, 0, 0, 1'b1);
    frame( 2,  16'sd4096, 2'b00, 0, 0, 1'b1);
    frame( 3,  16'sd4096, 2'b01, 1, 0, 1'b1);
    frame( 4,  16'sd3500, 2'b01, 0, 0, 1'b1);
    frame( 5,  16'sd2999, 2'b01, 0, 0, 1'b1);
    frame( 6,  16'sd2999, 2'b01, 0, 0, 1'b1);
    frame( 7,  16'sd2999, 2'b00, 1, 0, 1'b1);
    // Flipping candidate never settles
    frame( 8,  16'sd5000, 2'b00, 0, 0, 1'b1);
    frame( 9, -16'sd5000, 2'b00, 0, 0, 1'b1);
    frame(10,  16'sd5000, 2'b00, 0, 0, 1'b1);

    // Reset mid-frame: partial high bytes must be discarded
    tick(1'b1, 4'd0, 8'h7F, 1'b0);
    tick(1'b1, 4'd2, 8'h7F, 1'b0);
    tick(1'b1, 4'd4, 8'h7F, 1'b0);
    do_reset();
    repeat (4) tick(1'b0, 4'd0, 8'd0, 1'b0);
    check("post_rst_no_rescan", 0, {31'd0, o_rescan}, 32'd0);
    frame(11, 16'sh1240, 2'b00, 0, 0, 1'b0);

    // Shake: first frame primes, then alternating +/-8000 hits
    do_reset();
    frame(21,  16'sd8000,  2'b00, 0, 0, 1'b1);
    frame(22, -16'sd8000,  2'b00, 0, 0, 1'b1);
    frame(23,  16'sd8000,  2'b00, 0, 0, 1'b1);
    frame(24, -16'sd8000,  2'b00, 0, 0, 1'b1);
    frame(25,  16'sd8000,  2'b00, 0, 1, 1'b1);
    // Full-scale swings: |diff| up to 65535 must still count
    frame(26, 16'sh8000,   2'b00, 0, 0, 1'b1);
    frame(27, 16'sh7FFF,   2'b00, 0, 0, 1'b1);
    frame(28, 16'sh8000,   2'b00, 0, 0, 1'b1);
    frame(29, 16'sh7FFF,   2'b00, 0, 1, 1'b1);
    // Left tilt, left hysteresis hold, then a swap candidate toward right
    frame(30, -16'sd5000,  2'b00, 0, 0, 1'b1);
    frame(31, -16'sd5000,  2'b00, 0, 0, 1'b1);
    frame(32, -16'sd5000,  2'b10, 1, 0, 1'b1);
    frame(33, -16'sd3500,  2'b10, 0, 0, 1'b1);
    frame(34,  16'sd5000,  2'b10, 0, 0, 1'b1);

    repeat (3) tick(1'b0, 4'd0, 8'd0, 1'b0);
    check("queue_drained", 0, q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mpu_motion_detector.md
# mpu_motion_detector

Downstream consumer of the MPU6050 register sequencer. It assembles the accelerometer bytes streamed on the sequencer's LOAD/ADR/DATA outputs into 16-bit X/Y/Z samples. At each completed frame it runs debounced, hysteretic tilt detection on X and optional shake detection. It then returns RESCAN to request the next frame. It replaces the single-bit sign comparator and drives the Tamagotchi's motion inputs.

## Interface
- THRESH, 16'sd4000, tilt entry threshold on |X| (signed, strict >)
- HYST, 16'sd1000, hysteresis subtracted from THRESH for tilt exit
- DEBOUNCE, 3, consecutive frames a new tilt candidate must persist (1..15)
- SHAKE_DELTA, 17'd12000, |X - Xprev| above which a frame counts as a shake hit
- SHAKE_COUNT, 4, hits needed within the window (1..15)
- SHAKE_WINDOW, 32, window length in frames (2..255)
- MCLK  in  1  system clock; the only clock
- nRST  in  1  asynchronous, active-low reset
- TIC  in  1  clock-enable strobe shared with sequencer and I2C master
- LOAD  in  1  sequencer byte-valid; qualified by TIC
- ADR  in  4  register index of DATA
- DATA  in  8  register byte
- COMPLETED  in  1  sequencer frame-done level; qualified by TIC
- RESCAN  out  1  request for next frame
- XOUT, YOUT, ZOUT  out  16 each  last evaluated sample, signed
- TILT  out  2  00 level, 01 right, 10 left; 11 never driven
- TILT_EVT  out  1  one-MCLK pulse on TILT change
- SHAKE  out  1  one-MCLK pulse on shake detection

## Operation
- Capture: on MCLK edge with TIC&&LOAD, write DATA to a staging byte. ADR 0..5 map to XH, XL, YH, YL, ZH, ZL. ADR 6..15 are ignored. Capture runs in every state.
- FSM states:
  - IDLE: on an edge with TIC&&COMPLETED, copy staging to XOUT/YOUT/ZOUT atomically and go to EVAL.
  - EVAL: one MCLK cycle. Update tilt and shake, then go to REQ.
  - REQ: RESCAN=1. Go to IDLE on the first edge with TIC=1; that TIC cycle is the last with RESCAN high.
- COMPLETED outside IDLE is ignored.
- Tilt candidate, from XOUT and current TILT:
  - From level: X > THRESH gives right; X < -THRESH gives left.
  - From right: stay while X > THRESH-HYST, otherwise level. Left mirrors this.
  - A direct right/left swap is allowed when X crosses the opposite threshold.
- Debounce:
  - If candidate ≠ TILT, increment the counter and compare it with DEBOUNCE. Reaching DEBOUNCE updates TILT, clears the counter and pulses TILT_EVT.
  - If candidate == TILT, clear the counter.
  - A candidate that changes value restarts the count at 1.
- Shake:
  - diff = X - Xprev, computed at 17 bits signed; magnitude 0..65535.
  - A frame is a hit when |diff| > SHAKE_DELTA. Hits saturate at 15; the window counter increments every frame.
  - When hits reach SHAKE_COUNT, pulse SHAKE and clear hits and window.
  - When the window reaches SHAKE_WINDOW without detection, clear both.
  - Xprev updates every EVAL.
  - The first frame after reset sets Xprev only: no hit, and the window counter does not advance.

## Timing
- Reset values: RESCAN=0, XOUT=YOUT=ZOUT=0, TILT=00, TILT_EVT=0, SHAKE=0, FSM=IDLE. Staging, counters and the Xprev-valid flag are also cleared.
- COMPLETED sampled at TIC edge N updates XOUT etc. at N. TILT/TILT_EVT/SHAKE change at N+1, with both pulses dropping at N+2. RESCAN rises at N+2.
- RESCAN falls on the edge ending the first TIC-high cycle in which it was high.
- If reset asserts mid-frame, all state clears asynchronously and the partial staging is discarded. After release the block waits in IDLE for COMPLETED and issues no spontaneous RESCAN.
- LOAD arriving on the same TIC edge as COMPLETED is captured into staging first. The XOUT copy uses that new byte, because staging is bypassed for the matching ADR.

## Configuration
- SHAKE_DETECT_EN defined: shake logic, Xprev and its counters are built.
- Undefined: SHAKE is tied 0, no delta or window logic is instantiated, and tilt behaviour and timing are unchanged.

## Test plan
- Reset with TIC every 4 cycles: all outputs 0 and RESCAN 0. The first COMPLETED yields RESCAN high through exactly one TIC cycle.
- Three frames with X=0x1000 (4096), DEBOUNCE=3: TILT 00→01 after the third frame, with a single TILT_EVT. A fourth frame at X=3500 keeps 01; X=2999 then starts the return to 00.
- Frame sequence X=5000, X=-5000, X=5000 (DEBOUNCE=3): candidate flips each frame and TILT stays 00.
- ADR=7 LOAD with DATA=0xFF during capture: XOUT/YOUT/ZOUT are unaffected.
- SHAKE_DETECT_EN on, X alternating ±8000 (|diff|=16000): SHAKE pulses on the 5th frame (4 hits, first frame primes only). With the macro off, SHAKE stays 0.
- X=-32768 then X=32767 (|diff|=65535): counted as a hit, with no overflow.
